// File: rtl/ps2_mouse_pkg.sv
// Shared PS/2 mouse constants, sequencer states and the init command table.
// WHEEL_DETECT_EN inserts the IntelliMouse knock after the reset step.
package ps2_mouse_pkg;

  typedef enum logic [2:0] {
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_RUN,
    ST_FAIL
  } state_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_SET_RES  = 8'hE8;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERROR    = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;

  localparam int STEP_W = 4;

`ifdef WHEEL_DETECT_EN
  localparam int                STEP_CNT    = 13;
  localparam logic [STEP_W-1:0] STEP_GET_ID = 4'd7;
`else
  localparam int                STEP_CNT    = 6;
`endif
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CNT - 1);

  function automatic logic [7:0] step_cmd(input logic [STEP_W-1:0] step,
                                          input logic [7:0]        rate,
                                          input logic [7:0]        resol);
    logic [7:0] b;
    b = 8'h00;
    case (step)
`ifdef WHEEL_DETECT_EN
      4'd0:  b = CMD_RESET;
      4'd1:  b = CMD_SET_RATE;
      4'd2:  b = 8'hC8;
      4'd3:  b = CMD_SET_RATE;
      4'd4:  b = 8'h64;
      4'd5:  b = CMD_SET_RATE;
      4'd6:  b = 8'h50;
      4'd7:  b = CMD_GET_ID;
      4'd8:  b = CMD_SET_RATE;
      4'd9:  b = rate;
      4'd10: b = CMD_SET_RES;
      4'd11: b = resol;
      4'd12: b = CMD_ENABLE;
`else
      4'd0:  b = CMD_RESET;
      4'd1:  b = CMD_SET_RATE;
      4'd2:  b = rate;
      4'd3:  b = CMD_SET_RES;
      4'd4:  b = resol;
      4'd5:  b = CMD_ENABLE;
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ps2_mouse_timeout.sv
// Loadable down-counter that saturates at zero; expired_o is high while the count is zero.
// Load takes priority over decrement.
module ps2_mouse_timeout #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ps2_mouse_init.sv
// PS/2 mouse configuration sequencer: reset, rate, resolution, enable, with ACK checks,
// timeouts, bounded retries and hot-plug re-init. WHEEL_DETECT_EN adds wheel detection.
module ps2_mouse_init
  import ps2_mouse_pkg::*;
#(
  parameter logic [7:0] SAMPLE_RATE = 8'd100,
  parameter logic [7:0] RESOLUTION  = 8'd2,
  parameter int         ACK_TIMEOUT = 200000,
  parameter int         BAT_TIMEOUT = 2000000,
  parameter int         MAX_RETRIES = 3,
  parameter int         TMR_W       = 21
) (
  input  logic       clk,
  input  logic       res,
  input  logic       restart,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       stream_en,
  output logic       init_done,
  output logic       init_fail,
  output logic [1:0] retry_cnt,
`ifdef WHEEL_DETECT_EN
  output logic       wheel_present,
`endif
  output logic [7:0] mouse_id
);

  localparam logic [TMR_W-1:0] ACK_TMO   = TMR_W'(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] BAT_TMO   = TMR_W'(BAT_TIMEOUT);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        retry_q, retry_d;
  logic [7:0]        mouse_id_q, mouse_id_d;
  logic              init_done_q, init_done_d;
  logic              aa_seen_q, aa_seen_d;
  logic              cmd_valid_q, stream_en_q, init_fail_q;
  logic [7:0]        cmd_data_q;
  logic              tmr_load, tmr_en, tmr_expired;
  logic [TMR_W-1:0]  tmr_val;
  logic              xfer, fail_ev;
`ifdef WHEEL_DETECT_EN
  logic              wheel_q, wheel_d;
`endif

  assign xfer   = (state_q == ST_SEND) && cmd_valid_q && cmd_ready;
  assign tmr_en = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_BAT) ||
                  (state_q == ST_WAIT_ID);

  ps2_mouse_timeout #(.W(TMR_W)) u_tmo (
    .clk        (clk),
    .res        (res),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    retry_d     = retry_q;
    mouse_id_d  = mouse_id_q;
    init_done_d = init_done_q;
    aa_seen_d   = aa_seen_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    fail_ev     = 1'b0;
`ifdef WHEEL_DETECT_EN
    wheel_d     = wheel_q;
`endif

    // A received byte on the timeout cycle wins over the timeout.
    case (state_q)
      ST_SEND: begin
        if (xfer) begin
          state_d  = ST_WAIT_ACK;
          tmr_load = 1'b1;
          tmr_val  = ACK_TMO;
        end
      end
      ST_WAIT_ACK: begin
        if (rx_valid) begin
          if (rx_data != RSP_ACK) begin
            fail_ev = 1'b1;
          end else if (step_q == '0) begin
            state_d  = ST_WAIT_BAT;
            tmr_load = 1'b1;
            tmr_val  = BAT_TMO;
`ifdef WHEEL_DETECT_EN
          end else if (step_q == STEP_GET_ID) begin
            state_d  = ST_WAIT_ID;
            tmr_load = 1'b1;
            tmr_val  = ACK_TMO;
`endif
          end else if (step_q == STEP_LAST) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
            aa_seen_d   = 1'b0;
          end else begin
            state_d = ST_SEND;
            step_d  = step_q + STEP_W'(1);
          end
        end else if (tmr_expired) begin
          fail_ev = 1'b1;
        end
      end
      ST_WAIT_BAT: begin
        if (rx_valid) begin
          if (rx_data == RSP_BAT_OK) begin
            state_d  = ST_WAIT_ID;
            tmr_load = 1'b1;
            tmr_val  = ACK_TMO;
          end else begin
            fail_ev = 1'b1;
          end
        end else if (tmr_expired) begin
          fail_ev = 1'b1;
        end
      end
      ST_WAIT_ID: begin
        if (rx_valid) begin
          mouse_id_d = rx_data;
`ifdef WHEEL_DETECT_EN
          if (step_q == STEP_GET_ID) wheel_d = (rx_data == 8'h03);
`endif
          state_d = ST_SEND;
          step_d  = step_q + STEP_W'(1);
        end else if (tmr_expired) begin
          fail_ev = 1'b1;
        end
      end
      ST_RUN: begin
        // Only 0xAA immediately followed by 0x00 means the mouse was re-plugged.
        if (rx_valid) begin
          if (aa_seen_q && (rx_data == 8'h00)) begin
            state_d     = ST_SEND;
            step_d      = '0;
            retry_d     = '0;
            init_done_d = 1'b0;
            aa_seen_d   = 1'b0;
          end else begin
            aa_seen_d = (rx_data == RSP_BAT_OK);
          end
        end
      end
      ST_FAIL: begin
      end
      default: begin
        state_d = ST_SEND;
        step_d  = '0;
      end
    endcase

    if (fail_ev) begin
      retry_d = retry_q + 2'd1;
      step_d  = '0;
      state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_SEND;
    end

    if (restart) begin
      state_d     = ST_SEND;
      step_d      = '0;
      retry_d     = '0;
      init_done_d = 1'b0;
      aa_seen_d   = 1'b0;
      tmr_load    = 1'b1;
      tmr_val     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_SEND;
      step_q      <= '0;
      retry_q     <= '0;
      mouse_id_q  <= 8'h00;
      init_done_q <= 1'b0;
      aa_seen_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= 8'h00;
      stream_en_q <= 1'b0;
      init_fail_q <= 1'b0;
`ifdef WHEEL_DETECT_EN
      wheel_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      retry_q     <= retry_d;
      mouse_id_q  <= mouse_id_d;
      init_done_q <= init_done_d;
      aa_seen_q   <= aa_seen_d;
      cmd_valid_q <= (state_d == ST_SEND);
      if (state_d == ST_SEND) begin
        cmd_data_q <= step_cmd(step_d, SAMPLE_RATE, RESOLUTION);
      end
      stream_en_q <= (state_d == ST_RUN);
      init_fail_q <= (state_d == ST_FAIL);
`ifdef WHEEL_DETECT_EN
      wheel_q     <= wheel_d;
`endif
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_data_q;
  assign stream_en = stream_en_q;
  assign init_done = init_done_q;
  assign init_fail = init_fail_q;
  assign retry_cnt = retry_q;
  assign mouse_id  = mouse_id_q;
`ifdef WHEEL_DETECT_EN
  assign wheel_present = wheel_q;
`endif

endmodule

// File: tb/tb_ps2_mouse_init.sv
// Directed bench for ps2_mouse_init: table-driven init sequences and hot-plug pairs,
// plus hand-written NAK, BAT error, backpressure, timeout/FAIL and reset sequences.
module tb_ps2_mouse_init;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       restart = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       stream_en, init_done, init_fail;
  logic [1:0] retry_cnt;
  logic [7:0] mouse_id;
`ifdef WHEEL_DETECT_EN
  logic       wheel_present;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_mouse_init #(
    .SAMPLE_RATE (8'd100),
    .RESOLUTION  (8'd2),
    .ACK_TIMEOUT (16),
    .BAT_TIMEOUT (40),
    .MAX_RETRIES (3)
  ) dut (
    .clk       (clk),
    .res       (res),
    .restart   (restart),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .stream_en (stream_en),
    .init_done (init_done),
    .init_fail (init_fail),
    .retry_cnt (retry_cnt),
`ifdef WHEEL_DETECT_EN
    .wheel_present (wheel_present),
`endif
    .mouse_id  (mouse_id)
  );

  // One init step: expected command byte and the mouse's replies (rsp[0] first).
  typedef struct packed {
    logic [7:0]      cmd;
    logic [1:0]      nrsp;
    logic [2:0][7:0] rsp;
  } row_t;

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       exp_run;
  } hp_t;

  row_t tbl [6];
  hp_t  hp  [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic accept_cmd(output logic [7:0] b, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    b  = 8'h00;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      if (cmd_valid) begin
        b = cmd_data;
        ok = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
      end
    end
  endtask

  task automatic expect_cmd(input string name, input logic [7:0] exp);
    logic [7:0] b;
    int n;
    bit ok;
    accept_cmd(b, n, ok);
    if (!ok) check({name, "_wait"}, 32'd0, 32'd1);
    else     check(name, {24'd0, b}, {24'd0, exp});
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      expect_cmd($sformatf("cmd_row%0d", r), tbl[r].cmd);
      for (int k = 0; k < int'(tbl[r].nrsp); k++) send_rx(tbl[r].rsp[k]);
    end
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int n;
    int bad;
    bit ok;

    tbl[0] = '{cmd: 8'hFF, nrsp: 2'd3, rsp: {8'h00, 8'hAA, 8'hFA}};
    tbl[1] = '{cmd: 8'hF3, nrsp: 2'd1, rsp: {16'h0000, 8'hFA}};
    tbl[2] = '{cmd: 8'h64, nrsp: 2'd1, rsp: {16'h0000, 8'hFA}};
    tbl[3] = '{cmd: 8'hE8, nrsp: 2'd1, rsp: {16'h0000, 8'hFA}};
    tbl[4] = '{cmd: 8'h02, nrsp: 2'd1, rsp: {16'h0000, 8'hFA}};
    tbl[5] = '{cmd: 8'hF4, nrsp: 2'd1, rsp: {16'h0000, 8'hFA}};
    hp[0]  = '{b0: 8'hAA, b1: 8'h08, exp_run: 1'b1};
    hp[1]  = '{b0: 8'h12, b1: 8'h00, exp_run: 1'b1};
    hp[2]  = '{b0: 8'hAA, b1: 8'h00, exp_run: 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd_data", {24'd0, cmd_data}, 32'h00);
    check("rst_stream_en", {31'd0, stream_en}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_init_fail", {31'd0, init_fail}, 32'd0);
    check("rst_retry_cnt", {30'd0, retry_cnt}, 32'd0);
    check("rst_mouse_id", {24'd0, mouse_id}, 32'h00);
    res = 1'b0;
    @(negedge clk);
    check("first_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("first_cmd_data", {24'd0, cmd_data}, 32'hFF);

    // Nominal init
    run_rows(0, 5);
    check("nom_stream_en", {31'd0, stream_en}, 32'd1);
    check("nom_init_done", {31'd0, init_done}, 32'd1);
    check("nom_mouse_id", {24'd0, mouse_id}, 32'h00);
    check("nom_retry_cnt", {30'd0, retry_cnt}, 32'd0);

    // Hot-plug pairs in RUN; only the last pair re-plugs
    for (int i = 0; i < 3; i++) begin
      send_rx(hp[i].b0);
      send_rx(hp[i].b1);
      check($sformatf("hp%0d_stream_en", i), {31'd0, stream_en}, {31'd0, hp[i].exp_run});
      check($sformatf("hp%0d_init_done", i), {31'd0, init_done}, {31'd0, hp[i].exp_run});
    end
    check("hp_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("hp_cmd_data", {24'd0, cmd_data}, 32'hFF);

    // Stray byte while offering a command is not an acknowledgement
    send_rx(8'hFA);
    check("stray_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("stray_cmd_data", {24'd0, cmd_data}, 32'hFF);

    // BAT error reply counts as a failure and restarts with 0xFF
    expect_cmd("bat_cmd", 8'hFF);
    send_rx(8'hFA);
    send_rx(8'hFC);
    check("bat_retry_cnt", {30'd0, retry_cnt}, 32'd1);
    run_rows(0, 5);
    check("bat_stream_en", {31'd0, stream_en}, 32'd1);
    check("bat_retry_kept", {30'd0, retry_cnt}, 32'd1);

    // NAK on the first 0xE8
    pulse_restart();
    check("rs_retry_cnt", {30'd0, retry_cnt}, 32'd0);
    check("rs_stream_en", {31'd0, stream_en}, 32'd0);
    check("rs_init_done", {31'd0, init_done}, 32'd0);
    run_rows(0, 2);
    expect_cmd("nak_e8", 8'hE8);
    send_rx(8'hFE);
    check("nak_retry_cnt", {30'd0, retry_cnt}, 32'd1);
    run_rows(0, 5);
    check("nak_stream_en", {31'd0, stream_en}, 32'd1);

    // Backpressure on the sample-rate argument
    pulse_restart();
    run_rows(0, 1);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!cmd_valid || cmd_data != 8'h64 || retry_cnt != 2'd0) bad++;
    end
    check("bp_hold_violations", bad, 32'd0);
    run_rows(2, 5);
    check("bp_stream_en", {31'd0, stream_en}, 32'd1);
    check("bp_retry_cnt", {30'd0, retry_cnt}, 32'd0);

    // No replies at all: three 0xFF attempts, then FAIL
    pulse_restart();
    expect_cmd("tmo_cmd1", 8'hFF);
    accept_cmd(b, n, ok);
    check("tmo_cmd2", {23'd0, ok, b}, {23'd0, 1'b1, 8'hFF});
    check("tmo_gap2", n, 32'd17);
    check("tmo_retry1", {30'd0, retry_cnt}, 32'd1);
    accept_cmd(b, n, ok);
    check("tmo_cmd3", {23'd0, ok, b}, {23'd0, 1'b1, 8'hFF});
    check("tmo_gap3", n, 32'd17);
    check("tmo_retry2", {30'd0, retry_cnt}, 32'd2);
    repeat (20) @(negedge clk);
    check("fail_init_fail", {31'd0, init_fail}, 32'd1);
    check("fail_retry_cnt", {30'd0, retry_cnt}, 32'd3);
    send_rx(8'hFA);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (cmd_valid || !init_fail) bad++;
    end
    check("fail_stays_idle", bad, 32'd0);
    pulse_restart();
    check("rs_fail_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("rs_fail_cmd_data", {24'd0, cmd_data}, 32'hFF);
    check("rs_fail_retry", {30'd0, retry_cnt}, 32'd0);
    check("rs_fail_init_fail", {31'd0, init_fail}, 32'd0);

    // res asserted in the middle of a transfer
    @(negedge clk);
    res = 1'b1;
    cmd_ready = 1'b1;
    @(negedge clk);
    check("midres_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("midres_cmd_data", {24'd0, cmd_data}, 32'h00);
    cmd_ready = 1'b0;
    res = 1'b0;
    @(negedge clk);
    check("midres_restart_cmd", {23'd0, cmd_valid, cmd_data}, {23'd0, 1'b1, 8'hFF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
